writeback_stage: RTL and testbench

MEM/WB pipeline register plus write-back logic for the LEGv8 pipeline.
- Drives the register file's single write port (wr, wv, rw).
- Applies load sign/zero extension, BL link writes and XZR write suppression.
- Exports a same-cycle forwarding tap and a retired-instruction counter.
- Sits between the data-memory stage and the register file.

---
 rtl/legv8_pkg.sv | 17 +
 rtl/writeback_stage_load_extender.sv | 26 ++
 rtl/writeback_stage.sv | 111 +++++++++++
 tb/tb_writeback_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline constants: load-size encodings and the
// architecturally special register numbers.
package legv8_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    LS_BYTE   = 2'b00,
    LS_HALF   = 2'b01,
    LS_WORD   = 2'b10,
    LS_DOUBLE = 2'b11
  } load_size_e;

  localparam logic [4:0] XZR_REG  = 5'd31;
  localparam logic [4:0] LINK_REG = 5'd30;

endpackage

// File: rtl/writeback_stage_load_extender.sv
// Selects the byte/half/word/double field of a load and zero- or
// sign-extends it to the full datapath width.
module load_extender
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = legv8_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [DATA_WIDTH-1:0] value
);

  always_comb begin
    value = data;
    case (load_size_e'(size))
      LS_BYTE: value = {{(DATA_WIDTH-8){sign_ext & data[7]}}, data[7:0]};
      LS_HALF: value = {{(DATA_WIDTH-16){sign_ext & data[15]}}, data[15:0]};
      LS_WORD: value = {{(DATA_WIDTH-32){sign_ext & data[31]}}, data[31:0]};
      // A double-word load has no room to extend, so signedness is moot.
      LS_DOUBLE: value = data;
      default: value = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back mux: drives the register-file
// write port, the forwarding tap and the retired-instruction counter.
module writeback_stage
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH  = legv8_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   mem_valid,
  input  logic [ADDR_WIDTH-1:0]  mem_rd,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_to_reg,
  input  logic                   mem_link,
  input  logic [1:0]             mem_load_size,
  input  logic                   mem_load_signed,
  input  logic [DATA_WIDTH-1:0]  mem_alu_result,
  input  logic [DATA_WIDTH-1:0]  mem_load_data,
  input  logic [DATA_WIDTH-1:0]  mem_pc,
  output logic [ADDR_WIDTH-1:0]  wr,
  output logic [DATA_WIDTH-1:0]  wv,
  output logic                   rw,
  output logic                   fwd_valid,
  output logic [ADDR_WIDTH-1:0]  fwd_rd,
  output logic [DATA_WIDTH-1:0]  fwd_value,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  logic                   wb_valid_reg;
  logic [ADDR_WIDTH-1:0]  wb_rd_reg;
  logic                   wb_reg_write_reg;
  logic                   wb_mem_to_reg_reg;
  logic                   wb_link_reg;
  logic [1:0]             wb_load_size_reg;
  logic                   wb_load_signed_reg;
  logic [DATA_WIDTH-1:0]  wb_alu_result_reg;
  logic [DATA_WIDTH-1:0]  wb_load_data_reg;
  logic [DATA_WIDTH-1:0]  wb_pc_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  logic [DATA_WIDTH-1:0]  load_value;

  // Flush only needs to kill valid; the payload fields may keep stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_reg       <= 1'b0;
      wb_rd_reg          <= '0;
      wb_reg_write_reg   <= 1'b0;
      wb_mem_to_reg_reg  <= 1'b0;
      wb_link_reg        <= 1'b0;
      wb_load_size_reg   <= '0;
      wb_load_signed_reg <= 1'b0;
      wb_alu_result_reg  <= '0;
      wb_load_data_reg   <= '0;
      wb_pc_reg          <= '0;
    end else if (flush) begin
      wb_valid_reg <= 1'b0;
    end else if (!stall) begin
      wb_valid_reg       <= mem_valid;
      wb_rd_reg          <= mem_rd;
      wb_reg_write_reg   <= mem_reg_write;
      wb_mem_to_reg_reg  <= mem_mem_to_reg;
      wb_link_reg        <= mem_link;
      wb_load_size_reg   <= mem_load_size;
      wb_load_signed_reg <= mem_load_signed;
      wb_alu_result_reg  <= mem_alu_result;
      wb_load_data_reg   <= mem_load_data;
      wb_pc_reg          <= mem_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (!flush && !stall && mem_valid) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  load_extender #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extender (
    .data     (wb_load_data_reg),
    .size     (wb_load_size_reg),
    .sign_ext (wb_load_signed_reg),
    .value    (load_value)
  );

  always_comb begin
    wr = wb_link_reg ? ADDR_WIDTH'(LINK_REG) : wb_rd_reg;
    if (wb_link_reg) begin
      wv = wb_pc_reg + DATA_WIDTH'(4);
    end else if (wb_mem_to_reg_reg) begin
      wv = load_value;
    end else begin
      wv = wb_alu_result_reg;
    end
    // XZR is a sink: never issue a write to it, even for BL-style links.
    rw = wb_valid_reg & (wb_reg_write_reg | wb_link_reg) & (wr != ADDR_WIDTH'(XZR_REG));
  end

  assign fwd_valid     = rw;
  assign fwd_rd        = rw ? wr : '0;
  assign fwd_value     = rw ? wv : '0;
  assign retired_count = count_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed checks of writeback_stage against a spec-level
// model of the WB register contents and retired-instruction total.
module tb_writeback_stage;
  import legv8_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_link, mem_load_signed;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_load_size;
  logic [63:0] mem_alu_result, mem_load_data, mem_pc;
  logic [4:0]  wr, fwd_rd, s_wr, s_fwd_rd;
  logic [63:0] wv, fwd_value, s_wv, s_fwd_value;
  logic        rw, fwd_valid, s_rw, s_fwd_valid;
  logic [31:0] retired_count;
  logic [3:0]  small_count;
  logic [175:0] got_bus;

  int compared = 0;
  int mismatched = 0;

  // Model of the instruction currently held in WB.
  logic        m_valid, m_regw, m_m2r, m_link, m_sgn;
  logic [4:0]  m_rd;
  logic [1:0]  m_size;
  logic [63:0] m_alu, m_ld, m_pc;
  int unsigned m_retired;

  always #5 clock = ~clock;

  writeback_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link), .mem_load_size(mem_load_size),
    .mem_load_signed(mem_load_signed), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc(mem_pc),
    .wr(wr), .wv(wv), .rw(rw), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_value(fwd_value), .retired_count(retired_count)
  );

  // Narrow-counter instance so the wrap can be reached in a few cycles.
  writeback_stage #(.COUNT_WIDTH(4)) dut_small (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link), .mem_load_size(mem_load_size),
    .mem_load_signed(mem_load_signed), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc(mem_pc),
    .wr(s_wr), .wv(s_wv), .rw(s_rw), .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd),
    .fwd_value(s_fwd_value), .retired_count(small_count)
  );

  assign got_bus = {rw, wr, wv, fwd_valid, fwd_rd, fwd_value, retired_count, small_count};

  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input logic sg);
    int bits = 8 << sz;
    logic [63:0] span, f;
    if (bits == 64) return d;
    span = 64'd1 << bits;
    f = d % span;
    if (sg && f >= (span >> 1)) f = f - span;
    return f;
  endfunction

  function automatic logic [175:0] exp_bus();
    logic [4:0]  wr_e;
    logic [63:0] wv_e;
    logic        rw_e;
    wr_e = m_link ? 5'd30 : m_rd;
    if (m_link)     wv_e = m_pc + 64'd4;
    else if (m_m2r) wv_e = ext_model(m_ld, m_size, m_sgn);
    else            wv_e = m_alu;
    rw_e = m_valid && (m_regw || m_link) && (wr_e != 5'd31);
    return {rw_e, wr_e, wv_e, rw_e, rw_e ? wr_e : 5'd0, rw_e ? wv_e : 64'd0,
            m_retired, 4'(m_retired % 16)};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_regw = 0; m_m2r = 0; m_link = 0; m_sgn = 0;
    m_rd = 0; m_size = 0; m_alu = 0; m_ld = 0; m_pc = 0; m_retired = 0;
  endtask

  // One clock edge; inputs are stable here, so the model reads them directly.
  task automatic tick();
    @(posedge clock);
    #1;
    if (flush) m_valid = 0;
    else if (!stall) begin
      m_valid = mem_valid; m_rd = mem_rd; m_regw = mem_reg_write; m_m2r = mem_mem_to_reg;
      m_link = mem_link; m_size = mem_load_size; m_sgn = mem_load_signed;
      m_alu = mem_alu_result; m_ld = mem_load_data; m_pc = mem_pc;
    end
    if (!flush && !stall && mem_valid) m_retired++;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; mem_valid = 0; mem_rd = 0; mem_reg_write = 0; mem_mem_to_reg = 0;
    mem_link = 0; mem_load_size = 0; mem_load_signed = 0;
    mem_alu_result = 0; mem_load_data = 0; mem_pc = 0;
  endtask

  task automatic rand_inputs();
    mem_valid = ($urandom_range(3) != 0);
    mem_rd = 5'($urandom);
    mem_reg_write = $urandom_range(1);
    mem_mem_to_reg = $urandom_range(1);
    mem_link = ($urandom_range(7) == 0);
    mem_load_size = 2'($urandom);
    mem_load_signed = $urandom_range(1);
    mem_alu_result = {$urandom, $urandom};
    mem_load_data = {$urandom, $urandom};
    mem_pc = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    compared++;
    if (got_bus !== 176'd0) begin
      mismatched++;
      $display("FAIL reset_state: got %h required %h", got_bus, 176'd0);
    end
    $display("txn reset rw=%b wr=%0d wv=%h count=%0d", rw, wr, wv, retired_count);
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_alu_writeback();
    set_idle();
    mem_valid = 1; mem_rd = 5; mem_reg_write = 1; mem_alu_result = 64'h1234;
    tick();
    compared++;
    if ({rw, wr, wv, fwd_valid, fwd_rd, fwd_value, retired_count} !==
        {1'b1, 5'd5, 64'h1234, 1'b1, 5'd5, 64'h1234, 32'd1}) begin
      mismatched++;
      $display("FAIL alu_directed: got rw=%b wr=%0d wv=%h fv=%b frd=%0d fval=%h cnt=%0d required 1/5/1234/1/5/1234/1",
               rw, wr, wv, fwd_valid, fwd_rd, fwd_value, retired_count);
    end
    $display("txn alu rd=5 rw=%b wr=%0d wv=%h", rw, wr, wv);
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      mem_link = 0; mem_mem_to_reg = 0;
      tick();
      compared++;
      if (got_bus !== exp_bus()) begin
        mismatched++;
        $display("FAIL alu_random[%0d]: got %h required %h", i, got_bus, exp_bus());
      end
      $display("txn alu rw=%b wr=%0d wv=%h", rw, wr, wv);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sizes [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic        signs [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] expect_v [4] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0,
                                  64'hFFFF_FFFF_8000_00F0, 64'h0000_0000_8000_00F0};
    set_idle();
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; mem_rd = 3; mem_reg_write = 1; mem_mem_to_reg = 1;
      mem_load_data = 64'h0000_0000_8000_00F0;
      mem_load_size = sizes[i]; mem_load_signed = signs[i];
      mem_alu_result = 64'hDEAD;
      tick();
      compared++;
      if (rw !== 1'b1 || wr !== 5'd3 || wv !== expect_v[i]) begin
        mismatched++;
        $display("FAIL load_directed[%0d]: got rw=%b wr=%0d wv=%h required 1/3/%h", i, rw, wr, wv, expect_v[i]);
      end
      $display("txn load size=%0d signed=%b wv=%h", sizes[i], signs[i], wv);
    end
    for (int i = 0; i < 24; i++) begin
      rand_inputs();
      mem_link = 0; mem_mem_to_reg = 1;
      tick();
      compared++;
      if (got_bus !== exp_bus()) begin
        mismatched++;
        $display("FAIL load_random[%0d]: got %h required %h", i, got_bus, exp_bus());
      end
      $display("txn load size=%0d signed=%b wv=%h", m_size, m_sgn, wv);
    end
  endtask

  task automatic test_link();
    set_idle();
    mem_valid = 1; mem_link = 1; mem_rd = 9; mem_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    mem_alu_result = 64'h55;
    tick();
    compared++;
    if (rw !== 1'b1 || wr !== 5'd30 || wv !== 64'd0 || fwd_valid !== 1'b1 || fwd_rd !== 5'd30) begin
      mismatched++;
      $display("FAIL link_wrap: got rw=%b wr=%0d wv=%h fv=%b frd=%0d required 1/30/0/1/30", rw, wr, wv, fwd_valid, fwd_rd);
    end
    $display("txn bl rw=%b wr=%0d wv=%h", rw, wr, wv);
    set_idle();
    mem_valid = 1; mem_rd = 31; mem_reg_write = 1; mem_alu_result = 64'hABCD;
    tick();
    compared++;
    if (rw !== 1'b0 || fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_value !== 64'd0) begin
      mismatched++;
      $display("FAIL xzr_suppress: got rw=%b fv=%b frd=%0d fval=%h required 0/0/0/0", rw, fwd_valid, fwd_rd, fwd_value);
    end
    $display("txn xzr rw=%b fwd_valid=%b", rw, fwd_valid);
  endtask

  task automatic test_stall_flush();
    int unsigned held_count;
    set_idle();
    mem_valid = 1; mem_rd = 7; mem_reg_write = 1; mem_alu_result = 64'h77;
    tick();
    held_count = m_retired;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      mem_valid = 1; stall = 1; flush = 0;
      tick();
      compared++;
      if (rw !== 1'b1 || wr !== 5'd7 || wv !== 64'h77 || retired_count !== held_count) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got rw=%b wr=%0d wv=%h cnt=%0d required 1/7/77/%0d",
                 i, rw, wr, wv, retired_count, held_count);
      end
      $display("txn stall rw=%b wr=%0d wv=%h cnt=%0d", rw, wr, wv, retired_count);
    end
    stall = 1; flush = 1;
    tick();
    compared++;
    if (rw !== 1'b0 || fwd_valid !== 1'b0 || retired_count !== held_count) begin
      mismatched++;
      $display("FAIL flush_beats_stall: got rw=%b fv=%b cnt=%0d required 0/0/%0d", rw, fwd_valid, retired_count, held_count);
    end
    $display("txn flush+stall rw=%b cnt=%0d", rw, retired_count);
  endtask

  task automatic test_async_reset();
    set_idle();
    mem_valid = 1; mem_rd = 12; mem_reg_write = 1; mem_alu_result = 64'hC0FFEE;
    tick();
    compared++;
    if (rw !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_write: got rw=%b required 1", rw);
    end
    #3 reset = 1;
    #1;
    model_clear();
    compared++;
    if (got_bus !== 176'd0) begin
      mismatched++;
      $display("FAIL async_reset: got %h required %h", got_bus, 176'd0);
    end
    $display("txn async_reset rw=%b cnt=%0d", rw, retired_count);
    #1 reset = 0;
    mem_valid = 1; mem_rd = 4; mem_reg_write = 1; mem_alu_result = 64'h4444;
    tick();
    compared++;
    if (got_bus !== exp_bus() || rw !== 1'b1 || retired_count !== 32'd1) begin
      mismatched++;
      $display("FAIL post_reset_capture: got %h required %h", got_bus, exp_bus());
    end
    $display("txn post_reset rw=%b wr=%0d wv=%h", rw, wr, wv);
  endtask

  task automatic test_counter_wrap();
    set_idle();
    mem_valid = 1; mem_reg_write = 1; mem_rd = 1;
    for (int i = 0; i < 20 && (m_retired % 16) != 15; i++) tick();
    compared++;
    if (small_count !== 4'hF || retired_count !== m_retired) begin
      mismatched++;
      $display("FAIL wrap_pre: got small=%0d main=%0d required 15/%0d", small_count, retired_count, m_retired);
    end
    tick();
    compared++;
    if (small_count !== 4'h0 || retired_count !== m_retired) begin
      mismatched++;
      $display("FAIL wrap_post: got small=%0d main=%0d required 0/%0d", small_count, retired_count, m_retired);
    end
    $display("txn wrap small=%0d main=%0d", small_count, retired_count);
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      tick();
      compared++;
      if (got_bus !== exp_bus()) begin
        mismatched++;
        $display("FAIL random_mix[%0d]: got %h required %h", i, got_bus, exp_bus());
      end
      $display("txn mix st=%b fl=%b rw=%b wr=%0d wv=%h cnt=%0d", stall, flush, rw, wr, wv, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu_writeback();
    test_loads();
    test_link();
    test_stall_flush();
    test_async_reset();
    test_counter_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
